mbr_mem_port: RTL and testbench

Memory buffer register (MBR) and memory-side port for the accumulator CPU datapath. It is the other end of the ACC→MBR path: it latches ACC data on a control strobe and runs a request/acknowledge read or write cycle to main memory. It also returns read data to the datapath on gated, zero-when-idle buses to ACC and BR. Sits between the register file and the memory, driven by the control unit's C-signals.

---
 rtl/mbr_mem_port_if.sv | 31 +++
 rtl/mbr_mem_port.sv | 117 +++++++++++
 tb/tb_mbr_mem_port.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbr_mem_port_if.sv
// Memory-side bus of the MBR port: request/acknowledge handshake,
// address, write data and read data.
interface mbr_mem_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;

  modport master (
    output o_mem_req,
    output o_mem_we,
    output o_mem_addr,
    output o_mem_wdata,
    input  i_mem_ack,
    input  i_mem_rdata
  );

  modport slave (
    input  o_mem_req,
    input  o_mem_we,
    input  o_mem_addr,
    input  o_mem_wdata,
    output i_mem_ack,
    output i_mem_rdata
  );
endinterface

// File: rtl/mbr_mem_port.sv
// Memory buffer register and request/acknowledge memory port
// for the accumulator datapath, with timeout abort.
module mbr_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_acc_mbr,
  input  logic              i_c_acc_mbr,
  input  logic [ADDR_W-1:0] i_mar_addr,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  input  logic              i_c_mbr_acc,
  input  logic              i_c_mbr_br,
  output logic [DATA_W-1:0] o_mbr_acc,
  output logic [DATA_W-1:0] o_mbr_br,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  mbr_mem_port_if.master    mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      mbr_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mbr_q   <= mbr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mbr_d   = mbr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_c_acc_mbr)
          mbr_d = i_acc_mbr;
        if (i_wr_req) begin
          addr_d  = i_mar_addr;
          cnt_d   = '0;
          state_d = S_WR;
        end else if (i_rd_req) begin
          addr_d  = i_mar_addr;
          cnt_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        // an ack on the timeout edge still completes
        if (mem.i_mem_ack) begin
          mbr_d   = mem.i_mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WR: begin
        if (mem.i_mem_ack)
          state_d = S_DONE;
        else if (cnt_q == TMO_LAST)
          state_d = S_ERR;
        else
          cnt_d = cnt_q + 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic req;
  logic we;

  always_comb begin
    req    = (state_q == S_RD) || (state_q == S_WR);
    we     = (state_q == S_WR);
    o_busy = req || (state_q == S_DONE);
    o_done = (state_q == S_DONE);
    o_err  = (state_q == S_ERR);
  end

  assign mem.o_mem_req   = req;
  assign mem.o_mem_we    = we;
  assign mem.o_mem_addr  = req ? addr_q : '0;
  assign mem.o_mem_wdata = we ? mbr_q : '0;

  assign o_mbr_acc = mbr_q & {DATA_W{i_c_mbr_acc}};
  assign o_mbr_br  = mbr_q & {DATA_W{i_c_mbr_br}};

endmodule

// File: tb/tb_mbr_mem_port.sv
// Directed bench for mbr_mem_port with a transaction-level
// reference model checked every falling edge.
module tb_mbr_mem_port;

  localparam int TMO = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_acc_mbr = '0;
  logic        i_c_acc_mbr = 1'b0;
  logic [7:0]  i_mar_addr = '0;
  logic        i_rd_req = 1'b0;
  logic        i_wr_req = 1'b0;
  logic        i_c_mbr_acc = 1'b0;
  logic        i_c_mbr_br = 1'b0;
  logic [15:0] o_mbr_acc, o_mbr_br;
  logic        o_busy, o_done, o_err;

  mbr_mem_port_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mbr_mem_port #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_acc_mbr   (i_acc_mbr),
    .i_c_acc_mbr (i_c_acc_mbr),
    .i_mar_addr  (i_mar_addr),
    .i_rd_req    (i_rd_req),
    .i_wr_req    (i_wr_req),
    .i_c_mbr_acc (i_c_mbr_acc),
    .i_c_mbr_br  (i_c_mbr_br),
    .o_mbr_acc   (o_mbr_acc),
    .o_mbr_br    (o_mbr_br),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .mem         (bus.master)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_errp = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 transfer, 2 done, 3 aborted
  int          ph;
  bit          m_we;
  int          m_el;
  logic [15:0] m_mbr;
  logic [7:0]  m_addr;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ph     <= 0;
      m_we   <= 1'b0;
      m_el   <= 0;
      m_mbr  <= '0;
      m_addr <= '0;
    end else begin
      case (ph)
        0: begin
          if (i_c_acc_mbr) m_mbr <= i_acc_mbr;
          if (i_wr_req || i_rd_req) begin
            ph     <= 1;
            m_we   <= i_wr_req;
            m_addr <= i_mar_addr;
            m_el   <= 1;
          end
        end
        1: begin
          if (bus.i_mem_ack) begin
            if (!m_we) m_mbr <= bus.i_mem_rdata;
            ph <= 2;
          end else if (m_el == TMO) begin
            ph <= 3;
          end else begin
            m_el <= m_el + 1;
          end
        end
        default: ph <= 0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (o_done) n_done++;
    if (o_err) n_errp++;
    chk("req", 32'(bus.o_mem_req), 32'(ph == 1));
    chk("we", 32'(bus.o_mem_we), 32'(ph == 1 && m_we));
    chk("addr", 32'(bus.o_mem_addr), (ph == 1) ? 32'(m_addr) : 32'd0);
    chk("wdata", 32'(bus.o_mem_wdata),
        (ph == 1 && m_we) ? 32'(m_mbr) : 32'd0);
    chk("busy", 32'(o_busy), 32'(ph == 1 || ph == 2));
    chk("done", 32'(o_done), 32'(ph == 2));
    chk("err", 32'(o_err), 32'(ph == 3));
    chk("mbr_acc", 32'(o_mbr_acc), i_c_mbr_acc ? 32'(m_mbr) : 32'd0);
    chk("mbr_br", 32'(o_mbr_br), i_c_mbr_br ? 32'(m_mbr) : 32'd0);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ack(input logic [15:0] d);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = d;
    tick();
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
  endtask

  task automatic load(input logic [15:0] d);
    i_acc_mbr   = d;
    i_c_acc_mbr = 1'b1;
    tick();
    i_c_acc_mbr = 1'b0;
    i_acc_mbr   = '0;
  endtask

  task automatic peek(input logic [15:0] exp, input string name);
    i_c_mbr_acc = 1'b1;
    i_c_mbr_br  = 1'b1;
    #1;
    chk(name, 32'(o_mbr_acc), 32'(exp));
    i_c_mbr_acc = 1'b0;
    i_c_mbr_br  = 1'b0;
  endtask

  int n;
  int d0;

  initial begin
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    i_c_mbr_acc = 1'b1;
    i_c_mbr_br  = 1'b1;
    #3;
    chk("rst_acc", 32'(o_mbr_acc), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_req", 32'(bus.o_mem_req), 32'd0);
    i_c_mbr_acc = 1'b0;
    i_c_mbr_br  = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    // ACC load then write with ack after 3 cycles
    load(16'h1234);
    i_wr_req = 1'b1; i_mar_addr = 8'h20;
    tick();
    i_wr_req = 1'b0; i_mar_addr = '0;
    chk("w_we", 32'(bus.o_mem_we), 32'd1);
    chk("w_wdata", 32'(bus.o_mem_wdata), 32'h1234);
    chk("w_addr", 32'(bus.o_mem_addr), 32'h20);
    d0 = n_done;
    tick(); tick();
    ack('0);
    chk("w_done", 32'(o_done), 32'd1);
    tick();
    chk("w_pulses", 32'(n_done - d0), 32'd1);
    peek(16'h1234, "w_gate_on");
    #1 chk("w_gate_off", 32'(o_mbr_acc), 32'd0);

    // ack while idle must be ignored
    ack(16'hDEAD);
    tick();

    // read of zero data, minimum latency
    load(16'hFFFF);
    i_rd_req = 1'b1; i_mar_addr = 8'h05;
    tick();
    i_rd_req = 1'b0;
    chk("r_addr", 32'(bus.o_mem_addr), 32'h05);
    ack(16'h0000);
    chk("r_lat2", 32'(o_done), 32'd1);
    tick();
    peek(16'h0000, "r_zero");

    // timeout with no ack
    load(16'h4321);
    d0 = n_done;
    i_rd_req = 1'b1; i_mar_addr = 8'h09;
    tick();
    i_rd_req = 1'b0;
    n = 0;
    while (bus.o_mem_req && n < 100) begin
      n++;
      tick();
    end
    chk("t_req_cycles", 32'(n), 32'(TMO));
    chk("t_err", 32'(o_err), 32'd1);
    chk("t_busy", 32'(o_busy), 32'd0);
    tick();
    chk("t_no_done", 32'(n_done - d0), 32'd0);
    chk("t_errp", 32'(n_errp), 32'd1);
    peek(16'h4321, "t_mbr");

    // ack on the last allowed cycle wins
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    repeat (TMO - 1) tick();
    ack(16'hABCD);
    chk("t15_done", 32'(o_done), 32'd1);
    chk("t15_err", 32'(o_err), 32'd0);
    tick();
    peek(16'hABCD, "t15_mbr");

    // both requests: write wins
    i_rd_req = 1'b1; i_wr_req = 1'b1; i_mar_addr = 8'h33;
    tick();
    i_rd_req = 1'b0; i_wr_req = 1'b0;
    chk("c_we", 32'(bus.o_mem_we), 32'd1);
    ack('0);
    tick();

    // ACC load during read is ignored
    i_rd_req = 1'b1; i_mar_addr = 8'h44;
    tick();
    i_rd_req = 1'b0;
    i_acc_mbr = 16'hBEEF; i_c_acc_mbr = 1'b1;
    tick();
    i_c_acc_mbr = 1'b0; i_acc_mbr = '0;
    ack(16'h1111);
    tick();
    peek(16'h1111, "c_noload");

    // read request during write is ignored
    i_wr_req = 1'b1; i_mar_addr = 8'h55;
    tick();
    i_wr_req = 1'b0;
    i_rd_req = 1'b1; i_mar_addr = 8'h66;
    tick();
    chk("c_keep_we", 32'(bus.o_mem_we), 32'd1);
    chk("c_keep_addr", 32'(bus.o_mem_addr), 32'h55);
    i_rd_req = 1'b0;
    ack('0);
    tick();

    // load and write in the same cycle
    i_acc_mbr = 16'h00A5; i_c_acc_mbr = 1'b1;
    i_wr_req = 1'b1; i_mar_addr = 8'h77;
    tick();
    i_c_acc_mbr = 1'b0; i_wr_req = 1'b0; i_acc_mbr = '0;
    chk("lw_wdata", 32'(bus.o_mem_wdata), 32'h00A5);
    ack('0);
    tick();

    // async reset mid-write
    i_wr_req = 1'b1; i_mar_addr = 8'h88;
    tick();
    i_wr_req = 1'b0;
    tick();
    i_c_mbr_acc = 1'b1;
    i_c_mbr_br  = 1'b1;
    #1 i_rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.o_mem_req), 32'd0);
    chk("ar_we", 32'(bus.o_mem_we), 32'd0);
    chk("ar_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("ar_wdata", 32'(bus.o_mem_wdata), 32'd0);
    chk("ar_flags", 32'({o_busy, o_done, o_err}), 32'd0);
    chk("ar_bus", 32'({o_mbr_acc, o_mbr_br}), 32'd0);
    i_c_mbr_acc = 1'b0;
    i_c_mbr_br  = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    i_rd_req = 1'b1; i_mar_addr = 8'h12;
    tick();
    i_rd_req = 1'b0;
    tick();
    ack(16'h5A5A);
    chk("ar_done", 32'(o_done), 32'd1);
    tick();
    peek(16'h5A5A, "ar_mbr");
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
